imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension unit for the CPU datapath. It takes an IN_W-bit instruction immediate plus a mode select and produces an OUT_W-bit operand. Supported modes are sign extend, zero extend, upper-immediate placement and branch-offset (sign extend then shift left 2). The unit sits between decode and execute behind a valid/ready handshake. A 2-entry skid buffer provides full throughput under back-pressure.

---
 rtl/imm_ext_defs.sv | 14 +
 rtl/imm_ext_core.sv | 21 ++
 rtl/imm_extend_pipe.sv | 79 +++++++
 tb/tb_imm_extend_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_defs.sv
// imm_ext_defs: shared mode and state encodings for the immediate-extension pipe
package imm_ext_defs;
    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension selected by mode
module imm_ext_core
    import imm_ext_defs::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data
);
    logic [OUT_W-1:0] sext, zext, upper;
    assign sext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext  = {{(OUT_W-IN_W){1'b0}}, imm};
    assign upper = {imm, {(OUT_W-IN_W){1'b0}}};
    always_comb
        data = mode == MODE_SEXT  ? sext  :
               mode == MODE_ZEXT  ? zext  :
               mode == MODE_UPPER ? upper : sext << SHIFT;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: 1-cycle immediate extension behind a valid/ready skid buffer
module imm_extend_pipe
    import imm_ext_defs::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);
    if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
        $error("imm_extend_pipe: need 2 <= IN_W and OUT_W >= IN_W+2");
    end

    state_t           state;
    logic [OUT_W-1:0] ext, sk_data;
    logic [1:0]       sk_mode;
    logic             in_go, out_go;

    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext)
    );

    assign in_go     = in_valid & in_ready;
    assign out_valid = state != EMPTY;
    assign out_go    = out_valid & out_ready;

    // in_ready is registered so the upstream path never sees out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            out_data <= '0;
            out_mode <= '0;
            sk_data  <= '0;
            sk_mode  <= '0;
        end else begin
            case (state)
                EMPTY: if (in_go) begin
                    out_data <= ext;
                    out_mode <= in_mode;
                    state    <= ONE;
                end
                ONE: if (in_go && out_go) begin
                    out_data <= ext;
                    out_mode <= in_mode;
                end else if (in_go) begin
                    sk_data  <= ext;
                    sk_mode  <= in_mode;
                    state    <= TWO;
                    in_ready <= 1'b0;
                end else if (out_go) begin
                    state    <= EMPTY;
                end
                TWO: if (out_go) begin
                    out_data <= sk_data;
                    out_mode <= sk_mode;
                    state    <= ONE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for imm_extend_pipe (default and 12/20 variants)
module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode, out_mode;
    logic [31:0] out_data;

    logic        v_in_valid, v_in_ready, v_out_valid;
    logic [11:0] v_in_imm;
    logic [1:0]  v_in_mode, v_out_mode;
    logic [19:0] v_out_data;

    int total = 0;
    int bad = 0;
    int npop = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(20)) dut_v (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .in_imm(v_in_imm), .in_mode(v_in_mode), .out_valid(v_out_valid),
        .out_ready(1'b1), .out_data(v_out_data), .out_mode(v_out_mode)
    );

    function automatic logic [31:0] ref_ext(logic [31:0] imm, logic [1:0] m, int iw, int ow);
        logic [63:0] s, r;
        s = 64'(imm);
        if (imm[iw-1]) s = s | ~((64'd1 << iw) - 64'd1);
        case (m)
            2'd0: r = s;
            2'd1: r = 64'(imm);
            2'd2: r = 64'(imm) << (ow - iw);
            default: r = s << 2;
        endcase
        return 32'(r & ((64'd1 << ow) - 64'd1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] imm, input logic [1:0] m);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = m;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_imm   = 'x;
        in_mode  = 'x;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                npop++;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'hDEAD_DEAD);
                end else begin
                    logic [33:0] e;
                    e = q.pop_front();
                    chk("sb_data", out_data, e[31:0]);
                    chk("sb_mode", 32'(out_mode), 32'(e[33:32]));
                end
            end
            if (in_valid && in_ready)
                q.push_back({in_mode, ref_ext(32'(in_imm), in_mode, 16, 32)});
        end
    end

    initial begin
        int start;
        int waited;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(16'h1234, 2'd0);
        v_in_valid = 1'b0;
        v_in_imm = '0;
        v_in_mode = '0;
        // reset with in_valid held high
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        step();
        chk("rst_out_valid2", 32'(out_valid), 32'd0);
        chk("rst_out_data2", out_data, 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        rst_n = 1'b1;
        idle();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_no_emit", 32'(out_valid), 32'd0);

        // mode sweep, each result one cycle after accept
        drive(16'h8004, 2'd0); step(); chk("sext", out_data, 32'hFFFF8004); chk("sext_v", 32'(out_valid), 32'd1);
        drive(16'h8004, 2'd1); step(); chk("zext", out_data, 32'h00008004);
        drive(16'h8004, 2'd2); step(); chk("upper", out_data, 32'h80040000);
        drive(16'h8004, 2'd3); step(); chk("branch", out_data, 32'hFFFE0010); chk("branch_mode", 32'(out_mode), 32'd3);
        drive(16'h7FFF, 2'd3); step(); chk("branch_pos", out_data, 32'h0001FFFC);
        idle(); step();
        chk("sweep_drained", 32'(out_valid), 32'd0);

        // back-pressure: A held, B in skid, C stalls
        out_ready = 1'b0;
        drive(16'd1, 2'd0); step();
        drive(16'd2, 2'd0); step();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        drive(16'd3, 2'd0); step();
        chk("bp_hold_a", out_data, 32'd1);
        chk("bp_stall", 32'(in_ready), 32'd0);
        step();
        chk("bp_stable", out_data, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_b", out_data, 32'd2);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        idle();
        chk("bp_c", out_data, 32'd3);
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_done", 32'(out_valid), 32'd0);

        // full throughput
        start = npop;
        for (int i = 0; i < 64; i++) begin
            drive(16'($urandom), 2'($urandom_range(0, 3)));
            step();
            chk("tp_in_ready", 32'(in_ready), 32'd1);
            chk("tp_out_valid", 32'(out_valid), 32'd1);
        end
        idle();
        step();
        step();
        chk("tp_count", 32'(npop - start), 32'd64);

        // reset while two items are held
        out_ready = 1'b0;
        drive(16'hAAAA, 2'd1); step();
        drive(16'h5555, 2'd2); step();
        idle();
        chk("mid_two", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        chk("mid_no_emit", 32'(out_valid), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        drive(16'h0F0F, 2'd0); step(); idle();
        chk("mid_first", out_data, 32'h00000F0F);

        // 12/20 variant
        v_in_valid = 1'b1; v_in_imm = 12'hFFF; v_in_mode = 2'd0; step();
        chk("v_sext", 32'(v_out_data), 32'h000FFFFF);
        chk("v_sext_ref", 32'(v_out_data), ref_ext(32'hFFF, 2'd0, 12, 20));
        v_in_mode = 2'd2; step();
        chk("v_upper", 32'(v_out_data), 32'h000FFF00);
        v_in_imm = 12'h801; v_in_mode = 2'd3; step();
        chk("v_branch", 32'(v_out_data), 32'h000FE004);
        v_in_valid = 1'b0; step();
        chk("v_idle", 32'(v_out_valid), 32'd0);

        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            step();
            waited++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
